colour_mode_ctrl: RTL and testbench



---
 rtl/colour_mode_ctrl_pkg.sv | 33 +++
 rtl/colour_mode_ctrl_scancode_filter.sv | 65 ++++++
 rtl/colour_mode_ctrl.sv | 102 ++++++++++
 tb/tb_colour_mode_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/colour_mode_ctrl_pkg.sv
// rtl/colour_mode_ctrl_pkg.sv - shared colour, scancode and FSM encodings for colour_mode_ctrl
package colour_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        COL_WHITE = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } colour_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_C     = 8'h21;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BREAK = 2'd1;
    localparam logic [1:0] S_EXT   = 2'd2;

    // One-hot {Radd, Gadd, Badd}; WHITE drives no select.
    function automatic logic [2:0] decode_sel(input colour_t sel);
        case (sel)
            COL_RED:   decode_sel = 3'b100;
            COL_GREEN: decode_sel = 3'b010;
            COL_BLUE:  decode_sel = 3'b001;
            default:   decode_sel = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/colour_mode_ctrl_scancode_filter.sv
// rtl/colour_mode_ctrl_scancode_filter.sv - PS/2 set-2 byte filter emitting colour and cycle-toggle strobes
module scancode_filter
    import colour_mode_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       colour_req,
    output colour_t    colour_req_sel,
    output logic       cycle_toggle
);

    logic [1:0] state_q, state_d;
    logic       c_held_q, c_held_d;

    always_comb begin
        state_d        = state_q;
        c_held_d       = c_held_q;
        colour_req     = 1'b0;
        colour_req_sel = COL_WHITE;
        cycle_toggle   = 1'b0;
        if (key_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (key_code)
                        SC_BREAK: state_d = S_BREAK;
                        SC_EXT:   state_d = S_EXT;
                        SC_R: begin colour_req = 1'b1; colour_req_sel = COL_RED;   end
                        SC_G: begin colour_req = 1'b1; colour_req_sel = COL_GREEN; end
                        SC_B: begin colour_req = 1'b1; colour_req_sel = COL_BLUE;  end
                        SC_W: begin colour_req = 1'b1; colour_req_sel = COL_WHITE; end
                        SC_C: begin
                            // Typematic repeats of C are suppressed until its break code.
                            if (!c_held_q) begin
                                cycle_toggle = 1'b1;
                                c_held_d     = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_BREAK: begin
                    if (key_code == SC_C) c_held_d = 1'b0;
                    state_d = S_IDLE;
                end
                S_EXT: begin
                    state_d = (key_code == SC_BREAK) ? S_BREAK : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            c_held_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_held_q <= c_held_d;
        end
    end

endmodule

// File: rtl/colour_mode_ctrl.sv
// rtl/colour_mode_ctrl.sv - frame-synchronous RGB select sequencer driven by PS/2 keys
module colour_mode_ctrl
    import colour_mode_ctrl_pkg::*;
#(
    parameter int CYCLE_FRAMES = 60,
    parameter int FC_W         = 6
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       frame_start,
    output logic       Radd,
    output logic       Gadd,
    output logic       Badd,
    output logic       cycle_active,
    output logic       pending
);

    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(CYCLE_FRAMES - 1);

    logic    colour_req, cycle_toggle;
    colour_t colour_req_sel;

    colour_t         pend_sel_q, pend_sel_d;
    colour_t         cur_sel_q, cur_sel_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            pending_q, pending_d;
    logic            cycle_active_q, cycle_active_d;
    logic [2:0]      rgb_q, rgb_d;

    scancode_filter u_filter (
        .clk            (vga_clk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .colour_req     (colour_req),
        .colour_req_sel (colour_req_sel),
        .cycle_toggle   (cycle_toggle)
    );

    always_comb begin
        pend_sel_d     = pend_sel_q;
        cur_sel_d      = cur_sel_q;
        frame_cnt_d    = frame_cnt_q;
        pending_d      = pending_q;
        cycle_active_d = cycle_active_q;

        // Frame boundary acts on pre-edge request state; a key on the same edge queues behind it.
        if (frame_start) begin
            if (pending_q) begin
                cur_sel_d   = pend_sel_q;
                pending_d   = 1'b0;
                frame_cnt_d = '0;
            end else if (cycle_active_q) begin
                if (frame_cnt_q == LAST_FRAME) begin
                    frame_cnt_d = '0;
                    cur_sel_d   = colour_t'(cur_sel_q + 2'd1);
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end

        if (colour_req) begin
            pend_sel_d     = colour_req_sel;
            pending_d      = 1'b1;
            cycle_active_d = 1'b0;
        end else if (cycle_toggle) begin
            cycle_active_d = !cycle_active_q;
        end

        if (!cycle_active_d) frame_cnt_d = '0;

        rgb_d = decode_sel(cur_sel_d);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pend_sel_q     <= COL_WHITE;
            cur_sel_q      <= COL_WHITE;
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
            cycle_active_q <= 1'b0;
            rgb_q          <= 3'b000;
        end else begin
            pend_sel_q     <= pend_sel_d;
            cur_sel_q      <= cur_sel_d;
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
            cycle_active_q <= cycle_active_d;
            rgb_q          <= rgb_d;
        end
    end

    assign Radd         = rgb_q[2];
    assign Gadd         = rgb_q[1];
    assign Badd         = rgb_q[0];
    assign cycle_active = cycle_active_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_colour_mode_ctrl.sv
// tb/tb_colour_mode_ctrl.sv - directed scoreboard bench for colour_mode_ctrl
module tb_colour_mode_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       frame_start = 1'b0;
    logic       Radd, Gadd, Badd, cycle_active, pending;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];

    colour_mode_ctrl #(.CYCLE_FRAMES(3), .FC_W(6)) dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .frame_start  (frame_start),
        .Radd         (Radd),
        .Gadd         (Gadd),
        .Badd         (Badd),
        .cycle_active (cycle_active),
        .pending      (pending)
    );

    always #5 vga_clk = ~vga_clk;

    // Expected vector layout: {Radd, Gadd, Badd, cycle_active, pending}.
    task automatic step(input string tag, input logic rst, input logic kv,
                        input logic [7:0] code, input logic fs, input logic [4:0] expv);
        logic [4:0] obs;
        logic [4:0] want;
        @(negedge vga_clk);
        reset       = rst;
        key_valid   = kv;
        key_code    = code;
        frame_start = fs;
        exp_q.push_back(expv);
        @(posedge vga_clk);
        #1;
        reset       = 1'b0;
        key_valid   = 1'b0;
        frame_start = 1'b0;
        obs  = {Radd, Gadd, Badd, cycle_active, pending};
        want = exp_q.pop_front();
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic key(input string tag, input logic [7:0] code, input logic [4:0] expv);
        step(tag, 1'b0, 1'b1, code, 1'b0, expv);
    endtask

    task automatic frame(input string tag, input logic [4:0] expv);
        step(tag, 1'b0, 1'b0, 8'h00, 1'b1, expv);
    endtask

    task automatic idle(input string tag, input logic [4:0] expv);
        step(tag, 1'b0, 1'b0, 8'h00, 1'b0, expv);
    endtask

    initial begin
        logic [2:0] rgb;
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 5'b000_0_0);

        key("r_make", 8'h2D, 5'b000_0_1);
        for (int i = 0; i < 9; i++) idle("r_wait", 5'b000_0_1);
        frame("r_apply", 5'b100_0_0);

        key("g_make", 8'h34, 5'b100_0_1);
        key("b_make", 8'h32, 5'b100_0_1);
        frame("b_wins", 5'b001_0_0);
        key("brk_f0", 8'hF0, 5'b001_0_0);
        key("brk_b", 8'h32, 5'b001_0_0);
        frame("brk_nochg", 5'b001_0_0);

        key("w_make", 8'h1D, 5'b001_0_1);
        frame("w_apply", 5'b000_0_0);
        key("c_on", 8'h21, 5'b000_1_0);
        for (int k = 1; k <= 12; k++) begin
            case ((k / 3) % 4)
                1: rgb = 3'b100;
                2: rgb = 3'b010;
                3: rgb = 3'b001;
                default: rgb = 3'b000;
            endcase
            frame($sformatf("cycle_f%0d", k), {rgb, 2'b10});
        end
        key("c_repeat", 8'h21, 5'b000_1_0);
        key("c_brk_f0", 8'hF0, 5'b000_1_0);
        key("c_brk_21", 8'h21, 5'b000_1_0);
        key("c_off", 8'h21, 5'b000_0_0);
        frame("c_frozen", 5'b000_0_0);

        key("sim_r", 8'h2D, 5'b000_0_1);
        key("sim_f0", 8'hF0, 5'b000_0_1);
        key("sim_21", 8'h21, 5'b000_0_1);
        key("sim_c_on", 8'h21, 5'b000_1_1);
        step("sim_both", 1'b0, 1'b1, 8'h1D, 1'b1, 5'b100_0_1);
        frame("sim_white", 5'b000_0_0);

        key("ext_e0", 8'hE0, 5'b000_0_0);
        key("ext_r", 8'h2D, 5'b000_0_0);
        key("ext2_e0", 8'hE0, 5'b000_0_0);
        key("ext2_f0", 8'hF0, 5'b000_0_0);
        key("ext2_r", 8'h2D, 5'b000_0_0);
        key("ext_g", 8'h34, 5'b000_0_1);
        frame("ext_g_apply", 5'b010_0_0);

        key("rst_f0", 8'hF0, 5'b010_0_0);
        step("rst_mid", 1'b1, 1'b0, 8'h00, 1'b0, 5'b000_0_0);
        key("rst_stale_r", 8'h2D, 5'b000_0_1);
        frame("rst_r_apply", 5'b100_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
